// File: rtl/regfile_pkg.sv
// Shared types and default parameter values for the sweep-clearable register file.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int unsigned DEF_NREGS  = 32;
    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_NRD    = 2;
    localparam int unsigned DEF_BYPASS = 0;

endpackage

// File: rtl/regfile_z_param_if.sv
// Write/read/clear bus of the register file; the master drives requests, the slave returns data.
interface regfile_z_param_if
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NRD   = DEF_NRD
) ();
    localparam int unsigned AW = $clog2(NREGS);

    logic                          wen;
    logic [AW-1:0]                 waddr;
    logic [WIDTH-1:0]              wdata;
    logic [NRD-1:0][AW-1:0]        raddr;
    logic [NRD-1:0][WIDTH-1:0]     rdata;
    logic                          clr_req;
    logic                          clr_busy;

    modport master (
        output wen, waddr, wdata, raddr, clr_req,
        input  rdata, clr_busy
    );

    modport slave (
        input  wen, waddr, wdata, raddr, clr_req,
        output rdata, clr_busy
    );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Sweep-clear sequencer: walks idx from 1 to NREGS-1, one register per cycle.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr_req,
    output logic          o_clr_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_idx
);

    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);
    localparam logic [AW-1:0] FIRST_IDX = AW'(1);

    clr_state_t    r_state;
    clr_state_t    w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= FIRST_IDX;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // idx parks at 1 outside a sweep so a new sweep always starts at register 1
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt = CLEAR;
                    w_idx_nxt   = FIRST_IDX;
                end
            end
            CLEAR: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = FIRST_IDX;
                end else begin
                    w_idx_nxt = r_idx + AW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = FIRST_IDX;
            end
        endcase
    end

    assign o_clr_busy = (r_state == CLEAR);
    assign o_clr_we   = (r_state == CLEAR);
    assign o_clr_idx  = r_idx;

endmodule

// File: rtl/regfile_z_param.sv
// Parameterised register file with hardwired-zero r0, combinational reads,
// optional write forwarding and a one-register-per-cycle sweep clear.
module regfile_z_param
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS  = DEF_NREGS,
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned NRD    = DEF_NRD,
    parameter int unsigned BYPASS = DEF_BYPASS
) (
    input  logic             clk,
    input  logic             reset,
    regfile_z_param_if.slave bus
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [WIDTH-1:0]          r_regs [NREGS];
    logic                      w_clr_busy;
    logic                      w_clr_we;
    logic [AW-1:0]             w_clr_idx;
    logic                      w_wr_en;
    logic [NRD-1:0][WIDTH-1:0] w_rdata;

    regfile_clear_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_fsm (
        .clk        (clk),
        .reset      (reset),
        .i_clr_req  (bus.clr_req),
        .o_clr_busy (w_clr_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_idx  (w_clr_idx)
    );

    // Writes are only honoured while idle; r0 is never a legal target
    assign w_wr_en = bus.wen && (bus.waddr != '0) && !w_clr_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_clr_we) begin
            r_regs[w_clr_idx] <= '0;
        end else if (w_wr_en) begin
            r_regs[bus.waddr] <= bus.wdata;
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int p = 0; p < int'(NRD); p++) begin
            w_rdata[p] = (bus.raddr[p] == '0) ? '0 : r_regs[bus.raddr[p]];
            if ((BYPASS != 0) && w_wr_en && (bus.waddr == bus.raddr[p])) begin
                w_rdata[p] = bus.wdata;
            end
        end
    end

    assign bus.rdata    = w_rdata;
    assign bus.clr_busy = w_clr_busy;

endmodule

// File: tb/tb_regfile_z_param.sv
// Scoreboard bench: three register-file instances (default/no-forward, default/forward,
// 16x8 with 4 read ports and forwarding) checked against a queue-based reference model.
module tb_regfile_z_param;

    logic clk = 1'b0;
    logic reset;

    logic             ab_wen, ab_clr;
    logic [4:0]       ab_waddr;
    logic [31:0]      ab_wdata;
    logic [1:0][4:0]  ra_a, ra_b;

    logic             c_wen, c_clr;
    logic [3:0]       c_waddr;
    logic [7:0]       c_wdata;
    logic [3:0][3:0]  ra_c;

    regfile_z_param_if #(.NREGS(32), .WIDTH(32), .NRD(2)) if_a ();
    regfile_z_param_if #(.NREGS(32), .WIDTH(32), .NRD(2)) if_b ();
    regfile_z_param_if #(.NREGS(16), .WIDTH(8),  .NRD(4)) if_c ();

    assign if_a.wen = ab_wen;  assign if_a.waddr = ab_waddr; assign if_a.wdata = ab_wdata;
    assign if_a.raddr = ra_a;  assign if_a.clr_req = ab_clr;
    assign if_b.wen = ab_wen;  assign if_b.waddr = ab_waddr; assign if_b.wdata = ab_wdata;
    assign if_b.raddr = ra_b;  assign if_b.clr_req = ab_clr;
    assign if_c.wen = c_wen;   assign if_c.waddr = c_waddr;  assign if_c.wdata = c_wdata;
    assign if_c.raddr = ra_c;  assign if_c.clr_req = c_clr;

    regfile_z_param #(.NREGS(32), .WIDTH(32), .NRD(2), .BYPASS(0))
        u_dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    regfile_z_param #(.NREGS(32), .WIDTH(32), .NRD(2), .BYPASS(1))
        u_dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
    regfile_z_param #(.NREGS(16), .WIDTH(8), .NRD(4), .BYPASS(1))
        u_dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

    always #5 clk = ~clk;

    // Reference model: register contents plus a queue of addresses still awaiting clear
    logic [31:0] m_ab [32];
    logic [7:0]  m_c  [16];
    int          pend_ab [$];
    int          pend_c  [$];

    string       q_tag  [$];
    int          q_dut  [$];
    int          q_port [$];
    logic [31:0] q_exp  [$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int dut, input int port,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d port%0d got=%h expected=%h", tag, dut, port, act, exp);
        end
    endtask

    task automatic push(input string tag, input int dut, input int port, input logic [31:0] exp);
        q_tag.push_back(tag);
        q_dut.push_back(dut);
        q_port.push_back(port);
        q_exp.push_back(exp);
    endtask

    function automatic logic [31:0] actual(input int dut, input int port);
        logic [31:0] v;
        v = '0;
        case (dut)
            0: v = (port < 0) ? 32'(if_a.clr_busy) : if_a.rdata[port[0]];
            1: v = (port < 0) ? 32'(if_b.clr_busy) : if_b.rdata[port[0]];
            default: v = (port < 0) ? 32'(if_c.clr_busy) : 32'(if_c.rdata[port[1:0]]);
        endcase
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_ab[i] = '0;
        for (int i = 0; i < 16; i++) m_c[i] = '0;
        pend_ab.delete();
        pend_c.delete();
    endtask

    task automatic push_model();
        logic        busy_ab, busy_c;
        logic [4:0]  ad;
        logic [3:0]  cd;
        logic [31:0] e;
        busy_ab = (pend_ab.size() > 0);
        busy_c  = (pend_c.size() > 0);
        push("busy", 0, -1, 32'(busy_ab));
        push("busy", 1, -1, 32'(busy_ab));
        push("busy", 2, -1, 32'(busy_c));
        for (int p = 0; p < 2; p++) begin
            ad = ra_a[p[0]];
            push("rd_nofwd", 0, p, m_ab[ad]);
            ad = ra_b[p[0]];
            e  = m_ab[ad];
            if (!busy_ab && ab_wen && ab_waddr == ad && ad != 0) e = ab_wdata;
            push("rd_fwd", 1, p, e);
        end
        for (int p = 0; p < 4; p++) begin
            cd = ra_c[p[1:0]];
            e  = 32'(m_c[cd]);
            if (!busy_c && c_wen && c_waddr == cd && cd != 0) e = 32'(c_wdata);
            push("rd_rand", 2, p, e);
        end
    endtask

    task automatic model_edge();
        int a;
        if (pend_ab.size() > 0) begin
            a = pend_ab.pop_front();
            m_ab[a] = '0;
        end else begin
            if (ab_wen && ab_waddr != 0) m_ab[ab_waddr] = ab_wdata;
            if (ab_clr) for (int i = 1; i < 32; i++) pend_ab.push_back(i);
        end
        if (pend_c.size() > 0) begin
            a = pend_c.pop_front();
            m_c[a] = '0;
        end else begin
            if (c_wen && c_waddr != 0) m_c[c_waddr] = c_wdata;
            if (c_clr) for (int i = 1; i < 16; i++) pend_c.push_back(i);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are judged at the falling edge
    task automatic step();
        push_model();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            while (q_tag.size() > 0) begin
                int d, p;
                d = q_dut.pop_front();
                p = q_port.pop_front();
                check(q_tag.pop_front(), d, p, actual(d, p), q_exp.pop_front());
            end
        end
    end

    initial begin : driver
        int cnt;
        reset = 1'b1;
        ab_wen = 0; ab_clr = 0; ab_waddr = '0; ab_wdata = '0; ra_a = '0; ra_b = '0;
        c_wen = 0;  c_clr = 0;  c_waddr = '0;  c_wdata = '0;  ra_c = '0;
        model_reset();
        #1;
        push("reset_busy", 0, -1, 32'd0);
        step();
        step();
        reset = 1'b0;

        // Every address reads zero after reset
        for (int i = 0; i < 16; i++) begin
            ra_a[0] = 5'(2 * i); ra_a[1] = 5'(2 * i + 1);
            ra_b[0] = 5'(31 - i); ra_b[1] = 5'(i);
            for (int p = 0; p < 4; p++) ra_c[p] = 4'(i + p);
            push("post_reset_zero", 0, 1, 32'd0);
            step();
        end

        // r5 write then read alongside r0
        ab_wen = 1; ab_waddr = 5'd5; ab_wdata = 32'hDEADBEEF;
        step();
        ab_wen = 0; ra_a[0] = 5'd5; ra_a[1] = 5'd0;
        push("r5_read", 0, 0, 32'hDEADBEEF);
        push("r0_read", 0, 1, 32'h0);
        step();

        // Writes to r0 are dropped, also on the forwarding instance
        ab_wen = 1; ab_waddr = 5'd0; ab_wdata = 32'h12345678;
        ra_a = '0; ra_b = '0;
        push("r0_wr_before", 0, 0, 32'h0);
        push("r0_wr_fwd", 1, 1, 32'h0);
        step();
        ab_wen = 0;
        push("r0_wr_after", 0, 1, 32'h0);
        step();

        // Forwarding versus pre-write value on r3
        ab_wen = 1; ab_waddr = 5'd3; ab_wdata = 32'h11111111;
        step();
        ab_wdata = 32'hCAFEF00D; ra_a[0] = 5'd3; ra_b[0] = 5'd3;
        push("nofwd_old", 0, 0, 32'h11111111);
        push("fwd_new", 1, 0, 32'hCAFEF00D);
        step();
        ab_wen = 0;
        push("nofwd_next", 0, 0, 32'hCAFEF00D);
        step();

        // Sweep clear over r1..r31 holding their own index
        for (int i = 1; i < 32; i++) begin
            ab_wen = 1; ab_waddr = 5'(i); ab_wdata = 32'(i);
            step();
        end
        ab_wen = 0; ab_clr = 1;
        step();
        ab_clr = 0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!if_a.clr_busy) break;
            cnt++;
            ab_wen = 0;
            if (cnt == 3) begin
                ra_a[0] = 5'd1; ra_a[1] = 5'd2; ra_b[0] = 5'd3;
                push("sweep3_r1", 0, 0, 32'd0);
                push("sweep3_r2", 0, 1, 32'd0);
                push("sweep3_r3", 1, 0, 32'd3);
            end
            if (cnt == 10) begin
                ab_wen = 1; ab_waddr = 5'd7; ab_wdata = 32'hAAAAAAAA; ra_b[0] = 5'd7;
                ab_clr = 1;
                push("midsweep_nofwd", 1, 0, 32'd0);
            end
            step();
            ab_clr = 0;
        end
        check("busy_cycles", 0, -1, 32'(cnt), 32'd31);
        ab_wen = 0;
        for (int i = 0; i < 16; i++) begin
            ra_a[0] = 5'(2 * i); ra_a[1] = 5'(2 * i + 1);
            ra_b[0] = 5'd7; ra_b[1] = 5'(31 - i);
            push("after_sweep", 0, 0, 32'd0);
            push("after_sweep", 0, 1, 32'd0);
            push("r7_after_sweep", 1, 0, 32'd0);
            step();
        end

        // Reset part-way through a sweep
        for (int i = 1; i <= 10; i++) begin
            ab_wen = 1; ab_waddr = 5'(i); ab_wdata = 32'h5A5A5A5A;
            step();
        end
        ab_wen = 0; ab_clr = 1;
        step();
        ab_clr = 0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        model_reset();
        ra_a[0] = 5'd8; ra_a[1] = 5'd9; ra_b[0] = 5'd10; ra_b[1] = 5'd5;
        push("rst_mid_busy", 0, -1, 32'd0);
        push("rst_mid_r8", 0, 0, 32'd0);
        push("rst_mid_r10", 1, 0, 32'd0);
        step();
        reset = 1'b0;
        ab_wen = 1; ab_waddr = 5'd9; ab_wdata = 32'h0BADF00D;
        step();
        ab_wen = 0;
        push("idle_after_rst", 0, 1, 32'h0BADF00D);
        step();

        // Randomised traffic on the 16x8, 4-port instance
        for (int n = 0; n < 200; n++) begin
            c_wen   = 1'($urandom_range(0, 1));
            c_waddr = 4'($urandom_range(0, 15));
            c_wdata = 8'($urandom);
            c_clr   = ($urandom_range(0, 24) == 0);
            for (int p = 0; p < 4; p++)
                ra_c[p] = ($urandom_range(0, 2) == 0) ? c_waddr : 4'($urandom_range(0, 15));
            step();
        end
        c_wen = 0; c_clr = 0;
        step();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
